vhd_sector_client: RTL and testbench

- Core-side initiator for the HPS virtual-disk sector interface (sd_rd/sd_wr/sd_lba/sd_ack/sd_buff_*); hps_io is the responder.
- Accepts single-sector read/write commands from the disk controller in the system block and moves 512 bytes between hps_io and an internal sector buffer.
- Validates each request against the mounted image and reports done/error.
- Sits between hps_io and the future XT hard-disk controller; replaces the SPI sd_card path for VHD images.

---
 rtl/vhd_sector_client.sv | 234 +++++++++++++++++++++++
 tb/tb_vhd_sector_client.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vhd_sector_client.sv
// vhd_sector_client: core-side initiator for the hps_io virtual-disk sector interface.
// Moves one 512-byte sector between hps_io and a local dual-port buffer per request,
// checking each request against the mounted image before issuing it.
// Optional write protect input is enabled by defining VHD_WRPROT_EN.
module vhd_sector_client #(
    parameter logic [23:0] ACK_TIMEOUT  = 24'd5000000,
    parameter int unsigned SECTOR_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mounted,
    input  logic [8:0]  buf_addr,
    input  logic [7:0]  buf_din,
    input  logic        buf_we,
    output logic [7:0]  buf_dout,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_lba,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    input  logic        img_mounted,
`ifdef VHD_WRPROT_EN
    input  logic [63:0] img_size,
    input  logic        wp
`else
    input  logic [63:0] img_size
`endif
);

    localparam logic [9:0] FULL_COUNT = 10'(SECTOR_BYTES);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StXfer,
        StFin
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic        op_rd_q, op_rd_d;
    logic        fail_q, fail_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] to_cnt_q, to_cnt_d;
    logic        mounted_q, mounted_d;
    logic [31:0] sector_count_q, sector_count_d;
    logic        ack_q;
    logic        ack_rise;
    logic        hps_we;
    logic        wr_blocked;

    logic [7:0]  mem [0:511];
    logic [7:0]  buf_dout_q;
    logic [7:0]  sd_buff_din_q;

`ifdef VHD_WRPROT_EN
    assign wr_blocked = req_wr && wp;
`else
    assign wr_blocked = 1'b0;
`endif

    // A stale ack held over from IDLE must not start a transfer; only a fresh edge does.
    assign ack_rise = sd_ack && !ack_q;

    // Next-state and datapath control for the request/transfer sequence.
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        error_d        = 1'b0;
        sd_rd_d        = sd_rd_q;
        sd_wr_d        = sd_wr_q;
        sd_lba_d       = sd_lba_q;
        op_rd_d        = op_rd_q;
        fail_d         = fail_q;
        byte_cnt_d     = byte_cnt_q;
        to_cnt_d       = to_cnt_q;
        mounted_d      = mounted_q;
        sector_count_d = sector_count_q;
        hps_we         = 1'b0;

        if (img_mounted) begin
            mounted_d      = |img_size;
            sector_count_d = img_size[40:9];
        end

        unique case (state_q)
            StIdle: begin
                if (req_rd && req_wr) begin
                    error_d = 1'b1;
                end else if (req_rd || req_wr) begin
                    if (!mounted_q || (req_lba >= sector_count_q) || wr_blocked) begin
                        error_d = 1'b1;
                    end else begin
                        sd_lba_d = req_lba;
                        sd_rd_d  = req_rd;
                        sd_wr_d  = req_wr;
                        op_rd_d  = req_rd;
                        busy_d   = 1'b1;
                        fail_d   = 1'b0;
                        to_cnt_d = '0;
                        state_d  = StReq;
                    end
                end
            end
            StReq: begin
                if (img_mounted) begin
                    fail_d = 1'b1;
                end
                if (ack_rise) begin
                    sd_rd_d    = 1'b0;
                    sd_wr_d    = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = StXfer;
                end else if (to_cnt_q == ACK_TIMEOUT - 24'd1) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    fail_d  = 1'b1;
                    state_d = StFin;
                end else begin
                    to_cnt_d = to_cnt_q + 24'd1;
                end
            end
            StXfer: begin
                if (img_mounted) begin
                    fail_d = 1'b1;
                end
                if (op_rd_q && sd_buff_wr) begin
                    hps_we = 1'b1;
                    if (byte_cnt_q != FULL_COUNT) begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end
                if (!sd_ack) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
                if (fail_q || (op_rd_q && (byte_cnt_q != FULL_COUNT))) begin
                    error_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            sd_rd_q        <= 1'b0;
            sd_wr_q        <= 1'b0;
            sd_lba_q       <= '0;
            op_rd_q        <= 1'b0;
            fail_q         <= 1'b0;
            byte_cnt_q     <= '0;
            to_cnt_q       <= '0;
            mounted_q      <= 1'b0;
            sector_count_q <= '0;
            ack_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            sd_rd_q        <= sd_rd_d;
            sd_wr_q        <= sd_wr_d;
            sd_lba_q       <= sd_lba_d;
            op_rd_q        <= op_rd_d;
            fail_q         <= fail_d;
            byte_cnt_q     <= byte_cnt_d;
            to_cnt_q       <= to_cnt_d;
            mounted_q      <= mounted_d;
            sector_count_q <= sector_count_d;
            ack_q          <= sd_ack;
        end
    end

    // Buffer writes; core and hps writes are mutually exclusive because one needs busy low
    // and the other only happens during a read transfer.
    always_ff @(posedge clk) begin
        if (buf_we && !busy_q) begin
            mem[buf_addr] <= buf_din;
        end
        if (hps_we) begin
            mem[sd_buff_addr] <= sd_buff_dout;
        end
    end

    // Registered read ports for the core side and the hps side.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_dout_q    <= '0;
            sd_buff_din_q <= '0;
        end else begin
            buf_dout_q    <= mem[buf_addr];
            sd_buff_din_q <= mem[sd_buff_addr];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign mounted     = mounted_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_lba      = sd_lba_q;
    assign buf_dout    = buf_dout_q;
    assign sd_buff_din = sd_buff_din_q;

endmodule

// File: tb/tb_vhd_sector_client.sv
// Directed bench for vhd_sector_client with a hand-driven hps_io responder.
module tb_vhd_sector_client;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_rd, req_wr;
    logic [31:0] req_lba;
    logic        busy, done, error, mounted;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din;
    logic        buf_we;
    logic [7:0]  buf_dout;
    logic        sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        img_mounted;
    logic [63:0] img_size;
`ifdef VHD_WRPROT_EN
    logic        wp;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vhd_sector_client #(
        .ACK_TIMEOUT (24'd100),
        .SECTOR_BYTES(512)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_lba     (req_lba),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .mounted     (mounted),
        .buf_addr    (buf_addr),
        .buf_din     (buf_din),
        .buf_we      (buf_we),
        .buf_dout    (buf_dout),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_lba      (sd_lba),
        .sd_ack      (sd_ack),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .img_mounted (img_mounted),
`ifdef VHD_WRPROT_EN
        .img_size    (img_size),
        .wp          (wp)
`else
        .img_size    (img_size)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the first done/error pulse; both zero means the bound expired.
    task automatic wait_end(output logic d, output logic e);
        d = 1'b0;
        e = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || error) begin
                d = done;
                e = error;
                break;
            end
        end
    endtask

    task automatic pulse_req(input logic rd, input logic wr, input logic [31:0] lba);
        req_rd  = rd;
        req_wr  = wr;
        req_lba = lba;
        tick();
        req_rd  = 1'b0;
        req_wr  = 1'b0;
    endtask

    task automatic stream_rd(input int n, input logic [7:0] key);
        logic [8:0] a;
        for (int i = 0; i < n; i++) begin
            a            = 9'(i);
            sd_buff_addr = a;
            sd_buff_dout = a[7:0] ^ key;
            sd_buff_wr   = 1'b1;
            tick();
        end
        sd_buff_wr = 1'b0;
    endtask

    task automatic mount(input logic [63:0] size);
        img_size    = size;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
    endtask

    initial begin
        logic       d, e;
        logic [8:0] a;
        int         bad;
        int         cnt;

        reset = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; req_lba = '0;
        buf_addr = '0; buf_din = '0; buf_we = 1'b0;
        sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        img_mounted = 1'b0; img_size = '0;
`ifdef VHD_WRPROT_EN
        wp = 1'b0;
`endif
        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_mounted", mounted, 0);
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_buf_dout", buf_dout, 0);
        chk("rst_sd_buff_din", sd_buff_din, 0);
        reset = 1'b0;
        tick();

        // No image mounted yet.
        pulse_req(1, 0, 0);
        chk("nomount_error", error, 1);
        chk("nomount_sd_rd", sd_rd, 0);
        chk("nomount_busy", busy, 0);
        tick();
        chk("nomount_error_pulse", error, 0);

        mount(64'd1048576);
        chk("mounted", mounted, 1);

        // Read lba 5, ack after 10 cycles, with an ignored request while busy.
        pulse_req(1, 0, 5);
        chk("rd_sd_rd_latency", sd_rd, 1);
        chk("rd_sd_lba", sd_lba, 5);
        chk("rd_busy", busy, 1);
        tick(); tick(); tick();
        pulse_req(1, 0, 9);
        chk("busy_req_no_error", error, 0);
        chk("busy_req_lba_kept", sd_lba, 5);
        for (int i = 0; i < 4; i++) tick();
        chk("rd_sd_rd_held", sd_rd, 1);
        sd_ack = 1'b1;
        tick();
        chk("rd_sd_rd_drop_on_ack", sd_rd, 0);
        stream_rd(512, 8'hA5);
        sd_ack = 1'b0;
        wait_end(d, e);
        chk("rd_done", d, 1);
        chk("rd_no_error", e, 0);
        chk("rd_busy_clear", busy, 0);
        tick();
        chk("rd_done_single", done, 0);
        for (int i = 0; i < 5; i++) begin
            a = (i == 4) ? 9'd511 : 9'(i * 100 + 1);
            buf_addr = a;
            tick();
            chk("rd_buf_dout", buf_dout, {56'd0, a[7:0] ^ 8'hA5});
        end

        // Core fills buffer, then write to last sector.
        buf_we = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a        = 9'(i);
            buf_addr = a;
            buf_din  = a[7:0];
            tick();
        end
        buf_we = 1'b0;
        pulse_req(0, 1, 2047);
        chk("wr_sd_wr", sd_wr, 1);
        chk("wr_sd_rd_low", sd_rd, 0);
        chk("wr_sd_lba", sd_lba, 2047);
        // Core write while busy must be dropped.
        buf_addr = 9'd10; buf_din = 8'hFF; buf_we = 1'b1;
        tick();
        buf_we = 1'b0;
        sd_ack = 1'b1;
        tick();
        chk("wr_sd_wr_drop_on_ack", sd_wr, 0);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            a            = 9'(i);
            sd_buff_addr = a;
            tick();
            if (sd_buff_din !== a[7:0]) bad++;
            if (i == 300) chk("wr_byte300", sd_buff_din, 44);
        end
        chk("wr_stream_bad_bytes", bad, 0);
        sd_ack = 1'b0;
        wait_end(d, e);
        chk("wr_done", d, 1);
        chk("wr_no_error", e, 0);
        buf_addr = 9'd10;
        tick();
        chk("buf_we_ignored_busy", buf_dout, 10);

        // Out of range lba.
        pulse_req(1, 0, 2048);
        chk("oob_error", error, 1);
        chk("oob_sd_rd", sd_rd, 0);
        chk("oob_busy", busy, 0);
        tick();

        // Simultaneous read and write.
        pulse_req(1, 1, 0);
        chk("both_error", error, 1);
        chk("both_sd_rd", sd_rd, 0);
        chk("both_sd_wr", sd_wr, 0);
        tick();

`ifdef VHD_WRPROT_EN
        wp = 1'b1;
        pulse_req(0, 1, 1);
        chk("wp_error", error, 1);
        chk("wp_sd_wr", sd_wr, 0);
        tick();
        wp = 1'b0;
`endif

        // Ack timeout: request held exactly 100 cycles.
        pulse_req(1, 0, 1);
        cnt = 0;
        while (sd_rd && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("timeout_cycles", cnt, 100);
        wait_end(d, e);
        chk("timeout_error", e, 1);
        chk("timeout_no_done", d, 0);
        chk("timeout_busy", busy, 0);

        // Short read transfer.
        pulse_req(1, 0, 3);
        sd_ack = 1'b1;
        tick();
        stream_rd(300, 8'h00);
        sd_ack = 1'b0;
        wait_end(d, e);
        chk("short_error", e, 1);
        chk("short_no_done", d, 0);

        // Mount change mid-transfer.
        pulse_req(1, 0, 4);
        sd_ack = 1'b1;
        tick();
        stream_rd(200, 8'h11);
        mount(64'd1048576);
        stream_rd(512, 8'h11);
        sd_ack = 1'b0;
        wait_end(d, e);
        chk("midmount_error", e, 1);
        chk("midmount_no_done", d, 0);
        chk("midmount_mounted", mounted, 1);

        // Stale ack in IDLE does not start the transfer.
        sd_ack = 1'b1;
        tick();
        pulse_req(1, 0, 6);
        tick(); tick(); tick();
        chk("stale_ack_sd_rd_held", sd_rd, 1);
        sd_ack = 1'b0;
        tick();
        sd_ack = 1'b1;
        tick();
        chk("stale_ack_new_edge", sd_rd, 0);
        stream_rd(512, 8'h3C);
        sd_ack = 1'b0;
        wait_end(d, e);
        chk("stale_ack_done", d, 1);

        // Asynchronous reset during a transfer.
        pulse_req(1, 0, 7);
        sd_ack = 1'b1;
        tick();
        stream_rd(50, 8'h00);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_sd_rd", sd_rd, 0);
        chk("areset_sd_wr", sd_wr, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_error", error, 0);
        chk("areset_mounted", mounted, 0);
        sd_ack = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        mount(64'd1048576);
        pulse_req(1, 0, 8);
        chk("post_reset_sd_rd", sd_rd, 1);
        chk("post_reset_sd_lba", sd_lba, 8);
        sd_ack = 1'b1;
        tick();
        stream_rd(512, 8'h5A);
        sd_ack = 1'b0;
        wait_end(d, e);
        chk("post_reset_done", d, 1);
        buf_addr = 9'd77;
        tick();
        chk("post_reset_buf", buf_dout, 8'd77 ^ 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
